// File: rtl/ps2_key_filter.sv
// ps2_key_filter: PS/2 keyboard front end. It conditions the raw pins and
// receives 11-bit frames. It strips the E0/F0 prefixes and emits one make-code
// strobe per key press in the iVGA_CLK domain.
module ps2_key_filter #(
    parameter int FILTER_DEPTH   = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter bit ONE_SHOT       = 1'b1
) (
    input  logic       iVGA_CLK,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_in,
    output logic       key_en,
    output logic       parity_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    logic [1:0]              clk_sync, dat_sync;
    logic [FILTER_DEPTH-1:0] filt_sr;
    logic                    filt_lvl;
    logic                    fall, data_bit;
    rx_state_t               state, state_nxt;
    logic [2:0]              bitcnt;
    logic [7:0]              shreg;
    logic                    par_bit;
    logic [WD_W-1:0]         wd_cnt;
    logic                    timeout, frame_done, frame_ok;
    logic                    byte_vld;
    logic                    brk;
    logic                    held_vld;
    logic [7:0]              held;
    logic                    ignored;

    // Two-flop synchronisers; reset to the idle-high line level.
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // Glitch filter: the level moves only when every tap agrees.
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            filt_sr  <= '1;
            filt_lvl <= 1'b1;
        end else begin
            filt_sr <= {filt_sr[FILTER_DEPTH-2:0], clk_sync[1]};
            if (&filt_sr)
                filt_lvl <= 1'b1;
            else if (~|filt_sr)
                filt_lvl <= 1'b0;
        end
    end

    // Falling edge is the cycle the taps first agree on low; high for one cycle.
    assign fall       = filt_lvl & ~|filt_sr;
    assign data_bit   = dat_sync[1];
    assign timeout    = (state != RX_IDLE) && !fall && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign frame_done = fall && (state == RX_STOP);
    assign frame_ok   = (^{shreg, par_bit}) && data_bit;

    // Receive FSM state register.
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset)
            state <= RX_IDLE;
        else
            state <= state_nxt;
    end

    // Next state: advance on each fall; an idle watchdog abandons the frame, but fall wins.
    always_comb begin
        state_nxt = state;
        if (fall) begin
            case (state)
                RX_IDLE:   if (!data_bit) state_nxt = RX_DATA;
                RX_DATA:   if (bitcnt == 3'd7) state_nxt = RX_PARITY;
                RX_PARITY: state_nxt = RX_STOP;
                RX_STOP:   state_nxt = RX_IDLE;
                default:   state_nxt = RX_IDLE;
            endcase
        end else if (timeout) begin
            state_nxt = RX_IDLE;
        end
    end

    // Receive datapath: shift LSB first, capture parity, run the watchdog, flag the frame.
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            bitcnt     <= 3'd0;
            shreg      <= 8'h00;
            par_bit    <= 1'b0;
            wd_cnt     <= '0;
            byte_vld   <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (fall) begin
                case (state)
                    RX_IDLE: bitcnt <= 3'd0;
                    RX_DATA: begin
                        shreg  <= {data_bit, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                    end
                    RX_PARITY: par_bit <= data_bit;
                    default: ;
                endcase
            end
            if (state == RX_IDLE || fall)
                wd_cnt <= '0;
            else if (!timeout)
                wd_cnt <= wd_cnt + 1'b1;
            byte_vld   <= frame_done && frame_ok;
            parity_err <= frame_done && !frame_ok;
        end
    end

    assign ignored = (shreg == 8'hAA) || (shreg == 8'hFA) || (shreg == 8'hFE) ||
                     (shreg == 8'h00) || (shreg == 8'hFF);

    // Decode: the E0 prefix never changes the emitted code, so it is consumed without state.
    // F0 arms a release. The key being held is remembered so typematic repeats can be muted.
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            key_in   <= 8'h00;
            key_en   <= 1'b0;
            brk      <= 1'b0;
            held_vld <= 1'b0;
            held     <= 8'h00;
        end else begin
            key_en <= 1'b0;
            if (byte_vld) begin
                if (shreg == 8'hE0) begin
                    // prefix only
                end else if (shreg == 8'hF0) begin
                    brk <= 1'b1;
                end else if (ignored) begin
                    brk <= 1'b0;
                end else if (brk) begin
                    if (held_vld && shreg == held)
                        held_vld <= 1'b0;
                    brk <= 1'b0;
                end else begin
                    if (!(ONE_SHOT && held_vld && shreg == held)) begin
                        key_in <= shreg;
                        key_en <= 1'b1;
                    end
                    held     <= shreg;
                    held_vld <= 1'b1;
                    brk      <= 1'b0;
                end
            end
        end
    end

endmodule
